// File: rtl/pilot_phase_est.sv
// Pilot-based common-phase (mean pilot) and phase-slope (hi-lo group difference) estimator.
// Optional inter-symbol IIR smoothing of the phase output when PH_SMOOTH_EN is defined.
module pilot_phase_est #(
   parameter int unsigned DW       = 16,
   parameter int unsigned LOGN     = 3,
   parameter int unsigned GRP_BIT  = 1,
   parameter int unsigned ALPHA_SH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic signed [DW-1:0] datin_Re,
   input  logic signed [DW-1:0] datin_Im,
   input  logic                 datin_val,
   output logic signed [DW-1:0] ph_Re,
   output logic signed [DW-1:0] ph_Im,
   output logic signed [DW-1:0] slp_Re,
   output logic signed [DW-1:0] slp_Im,
   output logic                 ph_oval,
   output logic                 busy
);

   localparam int unsigned AW = DW + LOGN - 1;
   localparam int unsigned SW = DW + LOGN;
   localparam logic [LOGN-1:0] IDX_LAST = '1;
   localparam logic signed [SW-1:0] SAT_MAX = {{(LOGN+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN = {{(LOGN+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StAcc, StCalc, StOut} state_e;

   state_e               r_state, w_state_d;
   logic [LOGN-1:0]      r_idx;
   logic signed [AW-1:0] r_lo_re, r_lo_im, r_hi_re, r_hi_im;
   logic signed [SW-1:0] r_sum_re, r_sum_im, r_diff_re, r_diff_im;
   logic signed [DW-1:0] r_ph_re, r_ph_im, r_slp_re, r_slp_im;
   logic                 r_ph_oval;

   logic                 w_accept;
   logic signed [AW-1:0] w_re_ext, w_im_ext;
   logic signed [DW-1:0] w_ph_new_re, w_ph_new_im, w_ph_nxt_re, w_ph_nxt_im;
   logic signed [DW-1:0] w_slp_new_re, w_slp_new_im;

   function automatic logic signed [DW-1:0] f_sat(input logic signed [SW-1:0] x);
      if (x > SAT_MAX) return {1'b0, {(DW-1){1'b1}}};
      else if (x < SAT_MIN) return {1'b1, {(DW-1){1'b0}}};
      else return DW'(x);
   endfunction

   always_comb begin
      w_state_d = r_state;
      if (start) begin
         w_state_d = StAcc;
      end else begin
         unique case (r_state)
            StIdle: w_state_d = StIdle;
            StAcc:  if (datin_val && r_idx == IDX_LAST) w_state_d = StCalc;
            StCalc: w_state_d = StOut;
            StOut:  w_state_d = StIdle;
            default: w_state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= StIdle;
      else     r_state <= w_state_d;
   end

   // start has priority: a coincident sample is dropped
   assign w_accept = (r_state == StAcc) && datin_val && !start;
   assign w_re_ext = AW'(datin_Re);
   assign w_im_ext = AW'(datin_Im);

   assign w_ph_new_re  = DW'(r_sum_re >>> LOGN);
   assign w_ph_new_im  = DW'(r_sum_im >>> LOGN);
   assign w_slp_new_re = f_sat(r_diff_re >>> (LOGN - 1));
   assign w_slp_new_im = f_sat(r_diff_im >>> (LOGN - 1));

`ifdef PH_SMOOTH_EN
   logic r_primed;

   function automatic logic signed [DW-1:0] f_iir(input logic signed [DW-1:0] old_v,
                                                  input logic signed [DW-1:0] new_v);
      logic signed [DW:0] d;
      d = (DW+1)'(new_v) - (DW+1)'(old_v);
      return DW'((DW+1)'(old_v) + (d >>> ALPHA_SH));
   endfunction

   assign w_ph_nxt_re = r_primed ? f_iir(r_ph_re, w_ph_new_re) : w_ph_new_re;
   assign w_ph_nxt_im = r_primed ? f_iir(r_ph_im, w_ph_new_im) : w_ph_new_im;

   // only reset clears primed; an aborted symbol never loads it
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                r_primed <= 1'b0;
      else if (r_state == StOut && !start)    r_primed <= 1'b1;
   end
`else
   logic w_unused_alpha;
   assign w_unused_alpha = ^ALPHA_SH;
   assign w_ph_nxt_re    = w_ph_new_re;
   assign w_ph_nxt_im    = w_ph_new_im;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx     <= '0;
         r_lo_re   <= '0;
         r_lo_im   <= '0;
         r_hi_re   <= '0;
         r_hi_im   <= '0;
         r_sum_re  <= '0;
         r_sum_im  <= '0;
         r_diff_re <= '0;
         r_diff_im <= '0;
         r_ph_re   <= '0;
         r_ph_im   <= '0;
         r_slp_re  <= '0;
         r_slp_im  <= '0;
         r_ph_oval <= 1'b0;
      end else begin
         r_ph_oval <= 1'b0;
         if (start) begin
            r_idx   <= '0;
            r_lo_re <= '0;
            r_lo_im <= '0;
            r_hi_re <= '0;
            r_hi_im <= '0;
         end else if (w_accept) begin
            r_idx <= r_idx + LOGN'(1);
            if (r_idx[GRP_BIT]) begin
               r_hi_re <= r_hi_re + w_re_ext;
               r_hi_im <= r_hi_im + w_im_ext;
            end else begin
               r_lo_re <= r_lo_re + w_re_ext;
               r_lo_im <= r_lo_im + w_im_ext;
            end
         end
         if (r_state == StCalc && !start) begin
            r_sum_re  <= SW'(r_lo_re) + SW'(r_hi_re);
            r_sum_im  <= SW'(r_lo_im) + SW'(r_hi_im);
            r_diff_re <= SW'(r_hi_re) - SW'(r_lo_re);
            r_diff_im <= SW'(r_hi_im) - SW'(r_lo_im);
         end
         if (r_state == StOut && !start) begin
            r_ph_re   <= w_ph_nxt_re;
            r_ph_im   <= w_ph_nxt_im;
            r_slp_re  <= w_slp_new_re;
            r_slp_im  <= w_slp_new_im;
            r_ph_oval <= 1'b1;
         end
      end
   end

   assign ph_Re   = r_ph_re;
   assign ph_Im   = r_ph_im;
   assign slp_Re  = r_slp_re;
   assign slp_Im  = r_slp_im;
   assign ph_oval = r_ph_oval;
   assign busy    = (r_state != StIdle);

endmodule

// File: tb/tb_pilot_phase_est.sv
// Randomized bench for pilot_phase_est against an arithmetic reference model.
module tb_pilot_phase_est;
   localparam int DW = 16, LOGN = 3, GRP_BIT = 1, ALPHA_SH = 2, NP = 1 << LOGN;

   logic clk = 1'b0, rst, start, datin_val;
   logic signed [DW-1:0] datin_Re, datin_Im;
   logic signed [DW-1:0] ph_Re, ph_Im, slp_Re, slp_Im;
   logic ph_oval, busy;

   int n_checks = 0, n_errors = 0, n_oval = 0, n_oval0 = 0;
   int pr[NP], pim[NP];
   int m_ph_re = 0, m_ph_im = 0, m_slp_re = 0, m_slp_im = 0;
   bit m_primed = 1'b0;

   pilot_phase_est #(.DW(DW), .LOGN(LOGN), .GRP_BIT(GRP_BIT), .ALPHA_SH(ALPHA_SH)) dut (
      .clk(clk), .rst(rst), .start(start), .datin_Re(datin_Re), .datin_Im(datin_Im),
      .datin_val(datin_val), .ph_Re(ph_Re), .ph_Im(ph_Im), .slp_Re(slp_Re), .slp_Im(slp_Im),
      .ph_oval(ph_oval), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (ph_oval) n_oval++;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic int floor_div(input int a, input int d);
      if (a >= 0) return a / d;
      return -((-a + d - 1) / d);
   endfunction

   function automatic int sat(input int x);
      if (x > (1 << (DW-1)) - 1) return (1 << (DW-1)) - 1;
      if (x < -(1 << (DW-1))) return -(1 << (DW-1));
      return x;
   endfunction

   function automatic int wrap(input int x);
      int v = x & ((1 << DW) - 1);
      if (v >= (1 << (DW-1))) v -= (1 << DW);
      return v;
   endfunction

   function automatic int rnd_s();
      logic signed [DW-1:0] v;
      v = DW'($urandom);
      return int'(v);
   endfunction

   function automatic int smooth(input int old_v, input int new_v);
      return wrap(old_v + floor_div(new_v - old_v, 1 << ALPHA_SH));
   endfunction

   // Mean of all pilots; slope = (mean(hi) - mean(lo)), with group size NP/2
   task automatic model_update();
      int lo_re = 0, lo_im = 0, hi_re = 0, hi_im = 0, n_re, n_im;
      for (int i = 0; i < NP; i++) begin
         if (((i >> GRP_BIT) & 1) == 1) begin hi_re += pr[i]; hi_im += pim[i]; end
         else begin lo_re += pr[i]; lo_im += pim[i]; end
      end
      n_re = floor_div(lo_re + hi_re, NP);
      n_im = floor_div(lo_im + hi_im, NP);
      m_slp_re = sat(floor_div(hi_re - lo_re, NP / 2));
      m_slp_im = sat(floor_div(hi_im - lo_im, NP / 2));
`ifdef PH_SMOOTH_EN
      if (m_primed) begin n_re = smooth(m_ph_re, n_re); n_im = smooth(m_ph_im, n_im); end
`endif
      m_ph_re = n_re;
      m_ph_im = n_im;
      m_primed = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Idle junk (ignored) then start with a coincident valid sample that must be dropped
   task automatic begin_sym();
      n_oval0 = n_oval;
      for (int k = 0; k < 2; k++) begin
         datin_val = 1'b1; datin_Re = 16'h7FFF; datin_Im = 16'h7FFF; tick();
      end
      start = 1'b1; datin_Re = 16'h7FFF; datin_Im = 16'h8000;
      tick();
      start = 1'b0; datin_val = 1'b0;
      check_eq("busy_acc", int'(busy), 1);
   endtask

   task automatic feed(input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
               datin_val = 1'b0; datin_Re = DW'($urandom); datin_Im = DW'($urandom); tick();
            end
         end
         datin_val = 1'b1; datin_Re = DW'(pr[i]); datin_Im = DW'(pim[i]);
         tick();
      end
      datin_val = 1'b0;
   endtask

   task automatic finish_sym(input string tag);
      int cnt = 0;
      model_update();
      do begin tick(); cnt++; end while (!ph_oval && cnt < 8);
      check_eq({tag, "_lat"}, cnt, 2);
      check_eq({tag, "_ph_re"}, int'(ph_Re), m_ph_re);
      check_eq({tag, "_ph_im"}, int'(ph_Im), m_ph_im);
      check_eq({tag, "_slp_re"}, int'(slp_Re), m_slp_re);
      check_eq({tag, "_slp_im"}, int'(slp_Im), m_slp_im);
      tick();
      check_eq({tag, "_oval_off"}, int'(ph_oval), 0);
      check_eq({tag, "_busy_off"}, int'(busy), 0);
      check_eq({tag, "_n_oval"}, n_oval - n_oval0, 1);
      check_eq({tag, "_hold_re"}, int'(ph_Re), m_ph_re);
   endtask

   task automatic run_symbol(input string tag, input bit gaps);
      begin_sym();
      feed(NP, gaps);
      finish_sym(tag);
   endtask

   task automatic fill(input int lo_re, input int hi_re, input int im);
      for (int i = 0; i < NP; i++) begin
         pr[i] = (((i >> GRP_BIT) & 1) == 1) ? hi_re : lo_re;
         pim[i] = im;
      end
   endtask

   initial begin
      int n_snap;
      rst = 1'b1; start = 1'b0; datin_val = 1'b0; datin_Re = '0; datin_Im = '0;
      tick(); tick();
      check_eq("rst_ph_re", int'(ph_Re), 0);
      check_eq("rst_slp_re", int'(slp_Re), 0);
      check_eq("rst_oval", int'(ph_oval), 0);
      check_eq("rst_busy", int'(busy), 0);
      rst = 1'b0;
      tick();

      fill('h2000, 'h2000, 0);
      run_symbol("all", 1'b0);
      check_eq("tp_all_re", int'(ph_Re), 'h2000);
`ifdef PH_SMOOTH_EN
      fill(0, 0, 0);
      run_symbol("smooth", 1'b0);
      check_eq("tp_smooth_re", int'(ph_Re), 'h1800);
`else
      check_eq("tp_all_slp", int'(slp_Re), 0);
      fill('h1000, 'h3000, 'h0400);
      run_symbol("grp", 1'b1);
      check_eq("tp_grp_ph_re", int'(ph_Re), 'h2000);
      check_eq("tp_grp_slp_re", int'(slp_Re), 'h2000);
      check_eq("tp_grp_ph_im", int'(ph_Im), 'h0400);
      fill(-32768, 32767, 0);
      run_symbol("sat", 1'b0);
      check_eq("tp_sat_slp", int'(slp_Re), 32767);
      check_eq("tp_sat_ph", int'(ph_Re), -1);
`endif

      // Restart mid-symbol: only the second symbol produces a result
      fill('h1000, 'h1000, 0);
      begin_sym();
      feed(5, 1'b0);
      n_snap = n_oval0;
      fill('h0800, 'h0800, 0);
      begin_sym();
      n_oval0 = n_snap;
      feed(NP, 1'b1);
      finish_sym("restart");

      // start during CALC and during OUT discards the in-flight result
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < NP; i++) begin pr[i] = rnd_s(); pim[i] = rnd_s(); end
         begin_sym();
         feed(NP, 1'b0);
         if (w == 1) tick();
         start = 1'b1; tick(); start = 1'b0;
         for (int i = 0; i < NP; i++) begin pr[i] = rnd_s(); pim[i] = rnd_s(); end
         feed(NP, 1'b1);
         finish_sym(w == 0 ? "abort_calc" : "abort_out");
      end

      // Async reset in CALC, off the clock edge
      fill('h1234, 'h4321, -'h0777);
      begin_sym();
      feed(NP, 1'b0);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_ph_re", int'(ph_Re), 0);
      check_eq("arst_ph_im", int'(ph_Im), 0);
      check_eq("arst_slp_re", int'(slp_Re), 0);
      check_eq("arst_slp_im", int'(slp_Im), 0);
      check_eq("arst_busy", int'(busy), 0);
      #1 rst = 1'b0;
      m_primed = 1'b0; m_ph_re = 0; m_ph_im = 0; m_slp_re = 0; m_slp_im = 0;
      n_snap = n_oval;
      for (int k = 0; k < 5; k++) tick();
      check_eq("arst_no_oval", n_oval - n_snap, 0);
      fill('h0100, 'h0300, 'h0050);
      run_symbol("post_rst", 1'b1);

      for (int s = 0; s < 8; s++) begin
         for (int i = 0; i < NP; i++) begin
            if (s >= 6) begin
               pr[i] = $urandom_range(0, 1) ? 32767 : -32768;
               pim[i] = $urandom_range(0, 1) ? 32767 : -32768;
            end else begin
               pr[i] = rnd_s(); pim[i] = rnd_s();
            end
         end
         run_symbol("rand", 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
